// File: rtl/db_conv_scheduler.sv
// db_conv_scheduler: round-robin sharing of one fixed-latency power-to-dB converter, credit-gated issue,
// tagged retire into a FWFT result FIFO. Define PEAK_HOLD_EN to add per-channel peak-hold registers.
module db_conv_scheduler #(
  parameter int N_CH       = 4,
  parameter int CH_W       = 2,
  parameter int CONV_LAT   = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req_valid_i,
  input  logic [32*N_CH-1:0]   req_power_i,
  output logic [N_CH-1:0]      req_ready_o,
  output logic                 conv_valid_o,
  output logic [31:0]          conv_power_o,
  input  logic                 conv_valid_i,
  input  logic [15:0]          conv_dB_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [15:0]          res_dB_o,
  output logic [CH_W-1:0]      res_ch_o,
  output logic                 err_o,
  input  logic [CH_W-1:0]      peak_sel_i,
  input  logic                 peak_clr_i,
  output logic [15:0]          peak_dB_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CH_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_inflight;
  logic [CNT_W-1:0]   r_count;
  logic               r_conv_valid;
  logic [31:0]        r_conv_power;
  logic [CH_W-1:0]    r_conv_ch;
  logic [CONV_LAT-1:0] r_tag_v;
  logic [CH_W-1:0]    r_tag_ch [CONV_LAT];
  logic [CH_W+15:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic               r_err;

  logic [31:0]        w_pwr [N_CH];
  logic [31:0]        w_scan;
  logic               w_credit;
  logic               w_found;
  logic [CH_W-1:0]    w_gidx;
  logic [N_CH-1:0]    w_grant;
  logic               w_push;
  logic               w_pop;
  logic [CH_W+15:0]   w_head;

  for (genvar g = 0; g < N_CH; g++) begin : g_pwr
    assign w_pwr[g] = req_power_i[32*g +: 32];
  end

  // inflight already includes the registered issue stage, so pending issues are never double-booked
  assign w_credit = ({1'b0, r_inflight} + {1'b0, r_count}) < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_scan  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_scan = 32'(r_ptr) + i;
      if (w_scan >= 32'(N_CH)) w_scan = w_scan - 32'(N_CH);
      if (!w_found && w_credit && req_valid_i[w_scan[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_scan[CH_W-1:0];
      end
    end
    if (w_found) w_grant[w_gidx] = 1'b1;
  end

  assign w_push = r_tag_v[CONV_LAT-1];
  assign w_pop  = res_valid_o & res_ready_i;
  assign w_head = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_inflight   <= '0;
      r_count      <= '0;
      r_conv_valid <= 1'b0;
      r_conv_power <= '0;
      r_conv_ch    <= '0;
      r_tag_v      <= '0;
      for (int unsigned i = 0; i < CONV_LAT; i++) r_tag_ch[i] <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_err        <= 1'b0;
    end else begin
      r_conv_valid <= w_found;
      r_conv_ch    <= w_gidx;
      if (w_found) begin
        r_conv_power <= w_pwr[w_gidx];
        r_ptr        <= (w_gidx == CH_W'(N_CH-1)) ? '0 : w_gidx + 1'b1;
      end
      r_tag_v[0]  <= r_conv_valid;
      r_tag_ch[0] <= r_conv_ch;
      for (int unsigned i = 1; i < CONV_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_ch[i] <= r_tag_ch[i-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_found) - CNT_W'(w_push);
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) begin
        r_mem[r_wr] <= {r_tag_ch[CONV_LAT-1], conv_dB_i};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (conv_valid_i != w_push) r_err <= 1'b1;
    end
  end

  assign req_ready_o  = w_grant;
  assign conv_valid_o = r_conv_valid;
  assign conv_power_o = r_conv_power;
  assign res_valid_o  = (r_count != '0);
  assign res_dB_o     = w_head[15:0];
  assign res_ch_o     = w_head[CH_W+15:16];
  assign err_o        = r_err;

`ifdef PEAK_HOLD_EN
  logic [15:0] r_peak [N_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) r_peak[i] <= '0;
    end else begin
      if (w_push && (conv_dB_i > r_peak[r_tag_ch[CONV_LAT-1]]))
        r_peak[r_tag_ch[CONV_LAT-1]] <= conv_dB_i;
      // placed last so a clear overrides a same-cycle update of the same channel
      if (peak_clr_i) r_peak[peak_sel_i] <= '0;
    end
  end

  assign peak_dB_o = r_peak[peak_sel_i];
`else
  logic w_unused_peak;
  assign w_unused_peak = ^{peak_sel_i, peak_clr_i};
  assign peak_dB_o     = '0;
`endif

endmodule

// File: tb/tb_db_conv_scheduler.sv
// Bench for db_conv_scheduler: stub converter (dB = power[15:0]+1), arbitration table, scoreboard of results.
module tb_db_conv_scheduler;
  localparam int N_CH = 4, CH_W = 2, CONV_LAT = 5, FIFO_DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_CH-1:0]      rv  = '0;
  logic [31:0]          pw [N_CH];
  logic [32*N_CH-1:0]   req_power;
  logic [N_CH-1:0]      req_ready;
  logic                 conv_valid_o;
  logic [31:0]          conv_power_o;
  logic                 conv_valid_i;
  logic [15:0]          conv_dB_i;
  logic                 res_valid;
  logic                 rr = 1'b1;
  logic [15:0]          res_dB;
  logic [CH_W-1:0]      res_ch;
  logic                 err;
  logic [CH_W-1:0]      psel = '0;
  logic                 pclr = 1'b0;
  logic [15:0]          peak;

  always #5 clk = ~clk;

  always_comb begin
    req_power = '0;
    for (int k = 0; k < N_CH; k++) req_power[32*k +: 32] = pw[k];
  end

  db_conv_scheduler #(.N_CH(N_CH), .CH_W(CH_W), .CONV_LAT(CONV_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid_i(rv), .req_power_i(req_power), .req_ready_o(req_ready),
    .conv_valid_o(conv_valid_o), .conv_power_o(conv_power_o), .conv_valid_i(conv_valid_i),
    .conv_dB_i(conv_dB_i), .res_valid_o(res_valid), .res_ready_i(rr), .res_dB_o(res_dB),
    .res_ch_o(res_ch), .err_o(err), .peak_sel_i(psel), .peak_clr_i(pclr), .peak_dB_o(peak)
  );

  // stub converter with selectable latency (CONV_LAT or CONV_LAT+1)
  logic        sv [CONV_LAT+1];
  logic [15:0] sd [CONV_LAT+1];
  int          stub_lat = CONV_LAT;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= CONV_LAT; i++) begin sv[i] <= 1'b0; sd[i] <= '0; end
    end else begin
      sv[0] <= conv_valid_o;
      sd[0] <= conv_power_o[15:0] + 16'd1;
      for (int i = 1; i <= CONV_LAT; i++) begin sv[i] <= sv[i-1]; sd[i] <= sd[i-1]; end
    end
  end
  assign conv_valid_i = sv[stub_lat-1];
  assign conv_dB_i    = sd[stub_lat-1];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] q [$];
  logic sb_en = 1'b1;

  logic [N_CH-1:0] s_gnt;
  logic            s_conv_v, s_res_v, s_err;
  logic [31:0]     s_conv_p;
  logic [CH_W-1:0] s_res_ch;
  logic [15:0]     s_res_db, s_peak;

  typedef struct { logic [N_CH-1:0] valid; logic [N_CH-1:0] gnt; } vec_t;
  vec_t tab [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock: snapshot outputs at negedge, run the scoreboard, then step to just after posedge
  task automatic cyc();
    logic [17:0] e;
    logic [15:0] d;
    @(negedge clk);
    s_gnt = req_ready; s_conv_v = conv_valid_o; s_conv_p = conv_power_o;
    s_res_v = res_valid; s_res_ch = res_ch; s_res_db = res_dB; s_err = err; s_peak = peak;
    if (!rst && sb_en) begin
      chk("grant_onehot", 32'($countones(s_gnt) <= 1), 1);
      for (int k = 0; k < N_CH; k++)
        if (rv[k] && s_gnt[k]) begin
          d = pw[k][15:0] + 16'd1;
          q.push_back({2'(k), d});
        end
      if (s_res_v && rr) begin
        chk("sb_has_entry", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("res_ch", 32'(s_res_ch), 32'(e[17:16]));
          chk("res_dB", 32'(s_res_db), 32'(e[15:0]));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    rv = '0;
    while (q.size() != 0 && c < maxc) begin cyc(); c++; end
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic int idx_of(input logic [N_CH-1:0] g);
    int r = -1;
    for (int k = 0; k < N_CH; k++) if (g[k]) r = k;
    return r;
  endfunction

  initial begin
    logic [N_CH-1:0] prev_g;
    logic [31:0]     prev_p, last_p;
    int              prev_idx, idx, hs_cnt, popped;

    tab[0]  = '{4'b0000, 4'b0000};
    tab[1]  = '{4'b1010, 4'b0010};
    tab[2]  = '{4'b1010, 4'b1000};
    tab[3]  = '{4'b1010, 4'b0010};
    tab[4]  = '{4'b0001, 4'b0001};
    tab[5]  = '{4'b0000, 4'b0000};
    tab[6]  = '{4'b0001, 4'b0001};
    tab[7]  = '{4'b1111, 4'b0010};
    tab[8]  = '{4'b1111, 4'b0100};
    tab[9]  = '{4'b1111, 4'b1000};
    tab[10] = '{4'b1100, 4'b0100};
    tab[11] = '{4'b0110, 4'b0010};

    for (int k = 0; k < N_CH; k++) pw[k] = '0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;

    // reset state
    cyc();
    chk("rst_ready", s_gnt, 0);
    chk("rst_conv_valid", s_conv_v, 0);
    chk("rst_conv_power", s_conv_p, 0);
    chk("rst_res_valid", s_res_v, 0);
    chk("rst_res_ch", s_res_ch, 0);
    chk("rst_res_dB", s_res_db, 0);
    chk("rst_err", s_err, 0);
    chk("rst_peak", s_peak, 0);

    // arbitration table; pointer starts at 0
    prev_g = '0; prev_p = '0; last_p = '0;
    for (int i = 0; i < 12; i++) begin
      rv = tab[i].valid;
      for (int k = 0; k < N_CH; k++) pw[k] = $urandom;
      cyc();
      chk("tab_grant", s_gnt, tab[i].gnt);
      chk("tab_conv_valid", s_conv_v, 32'(prev_g != 0));
      chk("tab_conv_power", s_conv_p, (prev_g != 0) ? prev_p : last_p);
      if (prev_g != 0) last_p = prev_p;
      prev_g = tab[i].gnt;
      for (int k = 0; k < N_CH; k++) if (tab[i].gnt[k]) prev_p = pw[k];
    end
    rv = '0;
    cyc();
    chk("tab_conv_valid_last", s_conv_v, 32'(prev_g != 0));
    chk("tab_conv_power_last", s_conv_p, prev_p);
    drain(40);
`ifndef PEAK_HOLD_EN
    psel = 2'd2;
    cyc();
    chk("peak_tied_zero", s_peak, 0);
`endif

    // single request latency
    rv = 4'b0010; pw[1] = 32'h64;
    cyc();
    chk("single_grant", s_gnt, 4'b0010);
    rv = '0;
    cyc();
    chk("single_conv_valid", s_conv_v, 1);
    chk("single_conv_power", s_conv_p, 32'h64);
    for (int n = 2; n <= 7; n++) begin
      cyc();
      chk("single_res_valid", s_res_v, 32'(n == 7));
      if (n == 7) begin
        chk("single_res_ch", s_res_ch, 1);
        chk("single_res_dB", s_res_db, 32'h65);
      end
    end
    drain(10);

    // all channels continuously valid
    rv = '1; rr = 1'b1; prev_idx = -1;
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < N_CH; k++) pw[k] = $urandom;
      cyc();
      chk("c_issue", 32'(s_gnt != 0), 1);
      idx = idx_of(s_gnt);
      if (c > 0) chk("c_rr_order", idx, (prev_idx + 1) % N_CH);
      if (c >= 7) chk("c_throughput", s_res_v, 1);
      prev_idx = idx;
    end
    drain(40);

    // backpressure: credit stops issue after FIFO_DEPTH handshakes
    rr = 1'b0; rv = '1; hs_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      for (int k = 0; k < N_CH; k++) pw[k] = $urandom;
      cyc();
      if (s_gnt != 0) hs_cnt++;
    end
    chk("bp_handshakes", hs_cnt, FIFO_DEPTH);
    chk("bp_no_credit", s_gnt, 0);
    rv = '0; rr = 1'b1; popped = 0;
    for (int c = 0; c < 20 && popped < FIFO_DEPTH; c++) begin
      cyc();
      if (s_res_v) popped++;
    end
    chk("bp_drained", popped, FIFO_DEPTH);
    chk("bp_sb_empty", q.size(), 0);
    rv = '1;
    cyc();
    chk("bp_resume", 32'(s_gnt != 0), 1);
    drain(20);

    // converter one cycle late -> sticky error
    sb_en = 1'b0; stub_lat = CONV_LAT + 1;
    rv = 4'b0001; pw[0] = 32'h10;
    cyc();
    rv = '0;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      chk("err_sticky", s_err, 32'(n >= 7));
    end
    rst = 1'b1; stub_lat = CONV_LAT;
    cyc();
    rst = 1'b0;
    cyc();
    chk("err_cleared", s_err, 0);
    chk("err_rst_res_valid", s_res_v, 0);
    q.delete(); sb_en = 1'b1;

    // reset with samples in flight
    sb_en = 1'b0;
    rv = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      pw[0] = 32'h100 + 32'(n);
      cyc();
      chk("inflight_hs", s_gnt, 4'b0001);
    end
    rv = '0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    q.delete(); sb_en = 1'b1;
    for (int n = 0; n < 12; n++) begin
      cyc();
      chk("flush_res_valid", s_res_v, 0);
      chk("flush_err", s_err, 0);
    end

`ifdef PEAK_HOLD_EN
    psel = 2'd2; pclr = 1'b1;
    cyc();
    pclr = 1'b0;
    cyc();
    chk("peak_cleared", s_peak, 0);
    for (int n = 0; n < 3; n++) begin
      rv = 4'b0100;
      pw[2] = (n == 0) ? 32'd29 : (n == 1) ? 32'd49 : 32'd39;
      cyc();
    end
    drain(30);
    cyc();
    chk("peak_max", s_peak, 50);
    rv = 4'b0100; pw[2] = 32'd59;
    cyc();
    rv = '0;
    for (int n = 0; n < 5; n++) cyc();
    pclr = 1'b1;
    cyc();
    pclr = 1'b0;
    cyc();
    chk("peak_clr_wins", s_peak, 0);
    drain(10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
